// File: rtl/synopsys_ts_pkg.sv
// Shared definitions for the temperature-sensor APB integration layer:
// register offsets, field positions and the conversion-length helper.
package synopsys_ts_pkg;

   // Byte offsets of the four registers inside the 16-byte window
   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_DATA   = 4'h8;
   localparam logic [3:0] OFF_CONFIG = 4'hC;

   // Word select taken from PADDR[3:2]; values match the offsets above
   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_STATUS = 2'd1,
      REG_DATA   = 2'd2,
      REG_CONFIG = 2'd3
   } reg_sel_e;

   // CTRL bit indices
   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_CONT_BIT   = 1;
   localparam int CTRL_IRQ_EN_BIT = 2;

   // STATUS bit indices
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_RDY_BIT  = 1;

   // CONFIG field positions and widths
   localparam int CONV_LSB = 0;
   localparam int CONV_W   = 16;
   localparam int TRIM_LSB = 16;
   localparam int TRIM_W   = 12;

   // Conversion result width
   localparam int RESULT_W = 12;

   // Default reset values of the CONFIG fields
   localparam logic [CONV_W-1:0] CONV_CYCLES_RESET_DEF = 16'd16;
   localparam logic [TRIM_W-1:0] TRIM_RESET_DEF        = 12'h000;

   // A programmed length of zero still takes one clock
   function automatic logic [CONV_W-1:0] conv_effective(input logic [CONV_W-1:0] conv);
      return (conv == '0) ? CONV_W'(1) : conv;
   endfunction

endpackage

// File: rtl/synopsys_ts_sensor_integration_ts_sensor_model.sv
// Deterministic digital stand-in for the analog temperature sensor.
// Owns the conversion length counter, BUSY, the completed-conversion
// index and the result arithmetic; the APB layer above only stores results.
module ts_sensor_model
   import synopsys_ts_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start_req,
   input  logic [CONV_W-1:0]   conv_cycles,
   input  logic [TRIM_W-1:0]   trim,
   output logic                busy,
   output logic                done,
   output logic [RESULT_W-1:0] result
);

   logic [CONV_W-1:0]   remaining;
   logic [TRIM_W-1:0]   trim_latched;
   logic [RESULT_W-1:0] conv_idx;

   // The last busy cycle is the one where a single clock is left
   assign done   = busy && (remaining == CONV_W'(1));
   assign result = RESULT_W'(trim_latched) + conv_idx;

   // Conversion sequencing: CONV and TRIM are captured at start so later CONFIG writes only affect the next run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= 1'b0;
         remaining    <= '0;
         trim_latched <= '0;
         conv_idx     <= '0;
      end else if (!busy) begin
         if (start_req) begin
            busy         <= 1'b1;
            remaining    <= conv_effective(conv_cycles);
            trim_latched <= trim;
         end
      end else if (done) begin
         busy     <= 1'b0;
         conv_idx <= conv_idx + RESULT_W'(1);
      end else begin
         remaining <= remaining - CONV_W'(1);
      end
   end

endmodule

// File: rtl/synopsys_ts_sensor_integration.sv
// Zero-wait-state APB slave wrapping the temperature sensor model.
// Holds CTRL/STATUS/DATA/CONFIG, the address decode and the ready interrupt.
// Optional build macro: SYNOPSYS_TS_PSLVERR_EN enables PSLVERR for writes
// to DATA and for misaligned accesses; without it PSLVERR is tied low.
// In both builds such accesses never change register state.
module synopsys_ts_sensor_integration
   import synopsys_ts_pkg::*;
#(
   parameter logic [CONV_W-1:0] CONV_CYCLES_RESET = CONV_CYCLES_RESET_DEF,
   parameter logic [TRIM_W-1:0] TRIM_RESET        = TRIM_RESET_DEF
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSELx,
   input  logic [3:0]  PADDR,
   input  logic        PENABLE,
   input  logic [2:0]  PPROT,
   input  logic [3:0]  PSTRB,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        ts_vcal,
   output logic        ts_an_test_0,
   output logic        ts_an_test_1,
   output logic        ts_an_test_2,
   output logic        ts_an_test_3,
   output logic        ts_vss_sense,
   output logic        irq_ts_rdy
);

   logic                access;
   logic                aligned;
   reg_sel_e            reg_sel;
   logic                err_cond;
   logic                wr_en;
   logic                wr_ctrl;
   logic                wr_status;
   logic                wr_config;
   logic                start_pulse;
   logic                start_req;

   logic                cont_q;
   logic                irq_en_q;
   logic                rdy_q;
   logic                cont_restart;
   logic [RESULT_W-1:0] data_q;
   logic [CONV_W-1:0]   cfg_conv;
   logic [TRIM_W-1:0]   cfg_trim;

   logic                busy;
   logic                done;
   logic [RESULT_W-1:0] conv_result;

   logic                unused_bits;

   assign access    = PSELx & PENABLE;
   assign aligned   = (PADDR[1:0] == 2'b00);
   assign reg_sel   = reg_sel_e'(PADDR[3:2]);
   assign err_cond  = access & (!aligned | (PWRITE & (reg_sel == REG_DATA)));
   assign wr_en     = access & PWRITE & !err_cond;
   assign wr_ctrl   = wr_en & (reg_sel == REG_CTRL);
   assign wr_status = wr_en & (reg_sel == REG_STATUS);
   assign wr_config = wr_en & (reg_sel == REG_CONFIG);

   assign start_pulse = wr_ctrl & PSTRB[0] & PWDATA[CTRL_START_BIT];
   assign start_req   = start_pulse | cont_restart;

`ifdef SYNOPSYS_TS_PSLVERR_EN
   assign PSLVERR = err_cond;
`else
   assign PSLVERR = 1'b0;
`endif

   assign PREADY       = 1'b1;
   assign irq_ts_rdy   = rdy_q & irq_en_q;
   assign ts_vcal      = 1'b0;
   assign ts_an_test_0 = 1'b0;
   assign ts_an_test_1 = 1'b0;
   assign ts_an_test_2 = 1'b0;
   assign ts_an_test_3 = 1'b0;
   assign ts_vss_sense = 1'b0;

   assign unused_bits = ^{PPROT, PWDATA[31:28]};

   ts_sensor_model u_sensor (
      .clk         (PCLK),
      .rst         (PRESET),
      .start_req   (start_req),
      .conv_cycles (cfg_conv),
      .trim        (cfg_trim),
      .busy        (busy),
      .done        (done),
      .result      (conv_result)
   );

   // CTRL mode bits; START is a pulse and is never stored
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cont_q   <= 1'b0;
         irq_en_q <= 1'b0;
      end else if (wr_ctrl && PSTRB[0]) begin
         cont_q   <= PWDATA[CTRL_CONT_BIT];
         irq_en_q <= PWDATA[CTRL_IRQ_EN_BIT];
      end
   end

   // Sticky RDY: completion sets it and beats a simultaneous write-1-to-clear
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rdy_q <= 1'b0;
      end else if (done) begin
         rdy_q <= 1'b1;
      end else if (wr_status && PSTRB[0] && PWDATA[STATUS_RDY_BIT]) begin
         rdy_q <= 1'b0;
      end
   end

   // Capture each result and arm an automatic restart one edge later in continuous mode
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         data_q       <= '0;
         cont_restart <= 1'b0;
      end else begin
         cont_restart <= done & cont_q;
         if (done) begin
            data_q <= conv_result;
         end
      end
   end

   // CONFIG byte lanes, each gated by its own strobe
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cfg_conv <= CONV_CYCLES_RESET;
         cfg_trim <= TRIM_RESET;
      end else if (wr_config) begin
         if (PSTRB[0]) cfg_conv[7:0]  <= PWDATA[CONV_LSB +: 8];
         if (PSTRB[1]) cfg_conv[15:8] <= PWDATA[CONV_LSB + 8 +: 8];
         if (PSTRB[2]) cfg_trim[7:0]  <= PWDATA[TRIM_LSB +: 8];
         if (PSTRB[3]) cfg_trim[11:8] <= PWDATA[TRIM_LSB + 8 +: 4];
      end
   end

   // Read mux, valid in both setup and access phases; misaligned reads return zero
   always_comb begin
      PRDATA = '0;
      if (PSELx && !PWRITE && aligned) begin
         case (reg_sel)
            REG_CTRL: begin
               PRDATA[CTRL_CONT_BIT]   = cont_q;
               PRDATA[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_STATUS: begin
               PRDATA[STATUS_BUSY_BIT] = busy;
               PRDATA[STATUS_RDY_BIT]  = rdy_q;
            end
            REG_DATA: begin
               PRDATA[RESULT_W-1:0] = data_q;
            end
            REG_CONFIG: begin
               PRDATA[CONV_LSB +: CONV_W] = cfg_conv;
               PRDATA[TRIM_LSB +: TRIM_W] = cfg_trim;
            end
            default: PRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_synopsys_ts_sensor_integration.sv
// Directed bench for the temperature-sensor APB layer: register table plus
// hand-written sequences for conversion timing, continuous mode and resets.
module tb_synopsys_ts_sensor_integration;

`ifdef SYNOPSYS_TS_PSLVERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_irq;
      string       name;
   } vec_t;

   logic        PCLK;
   logic        PRESET;
   logic        PSELx;
   logic [3:0]  PADDR;
   logic        PENABLE;
   logic [2:0]  PPROT;
   logic [3:0]  PSTRB;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        ts_vcal;
   logic        ts_an_test_0;
   logic        ts_an_test_1;
   logic        ts_an_test_2;
   logic        ts_an_test_3;
   logic        ts_vss_sense;
   logic        irq_ts_rdy;

   int checks = 0;
   int errors = 0;

   vec_t tbl_reset [4];
   vec_t tbl_regs  [15];

   synopsys_ts_sensor_integration dut (
      .PCLK         (PCLK),
      .PRESET       (PRESET),
      .PSELx        (PSELx),
      .PADDR        (PADDR),
      .PENABLE      (PENABLE),
      .PPROT        (PPROT),
      .PSTRB        (PSTRB),
      .PWRITE       (PWRITE),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR),
      .ts_vcal      (ts_vcal),
      .ts_an_test_0 (ts_an_test_0),
      .ts_an_test_1 (ts_an_test_1),
      .ts_an_test_2 (ts_an_test_2),
      .ts_an_test_3 (ts_an_test_3),
      .ts_vss_sense (ts_vss_sense),
      .irq_ts_rdy   (irq_ts_rdy)
   );

   // Free-running 100 MHz clock
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Hard stop in case a sequence wedges
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic exp_irq, input string name);
      vec_t v;
      v.wr        = wr;
      v.addr      = addr;
      v.wdata     = wdata;
      v.strb      = strb;
      v.exp_rdata = exp_rdata;
      v.exp_err   = exp_err;
      v.exp_irq   = exp_irq;
      v.name      = name;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic idleBus();
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = 4'h0;
      PSTRB   = 4'h0;
      PWDATA  = 32'h0;
   endtask

   // Setup phase only, so PRDATA can be watched every cycle without a transfer completing
   task automatic holdRead(input logic [3:0] addr);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = addr;
   endtask

   task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic err);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = addr;
      PWDATA  = data;
      PSTRB   = strb;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      err = PSLVERR;
      @(posedge PCLK); #1;
      idleBus();
   endtask

   task automatic apbRead(input logic [3:0] addr, output logic [31:0] rdata, output logic err);
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = addr;
      PSTRB   = 4'h0;
      PWDATA  = 32'h0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      rdata = PRDATA;
      err   = PSLVERR;
      @(posedge PCLK); #1;
      idleBus();
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      logic err;
      apbWrite(addr, data, 4'hF, err);
   endtask

   task automatic rdCheck(input logic [3:0] addr, input logic [31:0] expected, input string name);
      logic [31:0] rd;
      logic        err;
      apbRead(addr, rd, err);
      checkOutput(name, rd, expected);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] rd;
      logic        err;
      if (v.wr) begin
         apbWrite(v.addr, v.wdata, v.strb, err);
      end else begin
         apbRead(v.addr, rd, err);
         checkOutput({v.name, "_rdata"}, rd, v.exp_rdata);
      end
      checkOutput({v.name, "_pslverr"}, {31'b0, err}, {31'b0, v.exp_err});
      checkOutput({v.name, "_irq"}, {31'b0, irq_ts_rdy}, {31'b0, v.exp_irq});
   endtask

   // Poll STATUS.RDY with a cycle budget; running out counts as a failure
   task automatic waitDone(input int budget, input string name);
      int  n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      holdRead(4'h4);
      while (!seen && n < budget) begin
         @(negedge PCLK);
         if (PRDATA[1] === 1'b1) seen = 1'b1;
         n++;
      end
      checkOutput({name, "_done_in_time"}, {31'b0, seen}, 32'd1);
      @(posedge PCLK); #1;
      idleBus();
   endtask

   initial begin
      logic [31:0] exp_busy [5];
      logic [31:0] exp_data [6];

      tbl_reset[0] = mk(1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rst_ctrl");
      tbl_reset[1] = mk(1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rst_status");
      tbl_reset[2] = mk(1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rst_data");
      tbl_reset[3] = mk(1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0010, 1'b0, 1'b0, "rst_config");

      tbl_regs[0]  = mk(1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0, 1'b0,   1'b0, "w1c_status");
      tbl_regs[1]  = mk(1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 1'b0, "status_cleared");
      tbl_regs[2]  = mk(1'b1, 4'hC, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0,   1'b0, "cfg_nostrb");
      tbl_regs[3]  = mk(1'b0, 4'hC, 32'h0,         4'h0, 32'h0123_0004, 1'b0, 1'b0, "cfg_after_nostrb");
      tbl_regs[4]  = mk(1'b1, 4'hC, 32'h00AB_0000, 4'h4, 32'h0, 1'b0,   1'b0, "cfg_lane2");
      tbl_regs[5]  = mk(1'b0, 4'hC, 32'h0,         4'h0, 32'h01AB_0004, 1'b0, 1'b0, "cfg_after_lane2");
      tbl_regs[6]  = mk(1'b1, 4'hC, 32'h0123_0004, 4'hF, 32'h0, 1'b0,   1'b0, "cfg_restore");
      tbl_regs[7]  = mk(1'b0, 4'hC, 32'h0,         4'h0, 32'h0123_0004, 1'b0, 1'b0, "cfg_restored");
      tbl_regs[8]  = mk(1'b1, 4'h8, 32'h0000_0FFF, 4'hF, 32'h0, ERR_EN, 1'b0, "data_write");
      tbl_regs[9]  = mk(1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0123, 1'b0, 1'b0, "data_kept");
      tbl_regs[10] = mk(1'b0, 4'h5, 32'h0,         4'h0, 32'h0000_0000, ERR_EN, 1'b0, "misaligned_read");
      tbl_regs[11] = mk(1'b1, 4'h1, 32'h0000_0001, 4'hF, 32'h0, ERR_EN, 1'b0, "misaligned_write");
      tbl_regs[12] = mk(1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 1'b0, "no_start");
      tbl_regs[13] = mk(1'b1, 4'h0, 32'h0000_0004, 4'hF, 32'h0, 1'b0,   1'b0, "ctrl_irq_only");
      tbl_regs[14] = mk(1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0004, 1'b0, 1'b0, "ctrl_readback");

      exp_busy = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h2};
      exp_data = '{32'h0, 32'h0, 32'h123, 32'h123, 32'h123, 32'h124};

      PPROT  = 3'b000;
      idleBus();
      PRESET = 1'b0;
      #2 PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;

      $display("[TB] reset values");
      checkOutput("rst_pready", {31'b0, PREADY}, 32'd1);
      checkOutput("rst_analog", {26'b0, ts_vcal, ts_an_test_0, ts_an_test_1, ts_an_test_2,
                                 ts_an_test_3, ts_vss_sense}, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(tbl_reset[i]);

      $display("[TB] first conversion, CONV=4 TRIM=0x123");
      wr(4'hC, 32'h0123_0004);
      wr(4'h0, 32'h0000_0005);
      holdRead(4'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         checkOutput($sformatf("busy_window_%0d", i), PRDATA, exp_busy[i]);
      end
      checkOutput("irq_after_first", {31'b0, irq_ts_rdy}, 32'd1);
      @(posedge PCLK); #1;
      idleBus();
      rdCheck(4'h8, 32'h0000_0123, "first_result");

      $display("[TB] register table");
      for (int i = 0; i < 15; i++) applyStimulus(tbl_regs[i]);

      $display("[TB] second start");
      wr(4'h0, 32'h0000_0005);
      waitDone(40, "second");
      rdCheck(4'h8, 32'h0000_0124, "second_result");
      rdCheck(4'h4, 32'h0000_0002, "second_status");

      $display("[TB] start while busy");
      wr(4'h4, 32'h0000_0002);
      wr(4'h0, 32'h0000_0005);
      wr(4'h0, 32'h0000_0005);
      repeat (8) @(posedge PCLK);
      #1;
      rdCheck(4'h4, 32'h0000_0002, "busy_start_status");
      rdCheck(4'h8, 32'h0000_0125, "busy_start_result");

      $display("[TB] W1C on completion edge");
      wr(4'h4, 32'h0000_0002);
      wr(4'h0, 32'h0000_0005);
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      wr(4'h4, 32'h0000_0002);
      rdCheck(4'h4, 32'h0000_0002, "w1c_collide_status");
      checkOutput("w1c_collide_irq", {31'b0, irq_ts_rdy}, 32'd1);
      rdCheck(4'h8, 32'h0000_0126, "w1c_collide_result");

      $display("[TB] reset mid-conversion");
      wr(4'h4, 32'h0000_0002);
      wr(4'h0, 32'h0000_0005);
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      checkOutput("midrst_irq", {31'b0, irq_ts_rdy}, 32'd0);
      rdCheck(4'h0, 32'h0000_0000, "midrst_ctrl");
      rdCheck(4'h8, 32'h0000_0000, "midrst_data");
      rdCheck(4'hC, 32'h0000_0010, "midrst_config");
      repeat (20) @(posedge PCLK);
      #1;
      rdCheck(4'h4, 32'h0000_0000, "midrst_status");

      $display("[TB] continuous mode, CONV=2");
      wr(4'hC, 32'h0123_0002);
      wr(4'h0, 32'h0000_0003);
      holdRead(4'h8);
      for (int i = 0; i < 6; i++) begin
         @(negedge PCLK);
         checkOutput($sformatf("cont_data_%0d", i), PRDATA, exp_data[i]);
      end
      wr(4'h0, 32'h0000_0000);
      repeat (8) @(posedge PCLK);
      #1;
      rdCheck(4'h8, 32'h0000_0125, "cont_last_result");
      rdCheck(4'h4, 32'h0000_0002, "cont_stopped_status");

      $display("[TB] CONV=0 behaves as one cycle");
      wr(4'hC, 32'h0000_0000);
      wr(4'h4, 32'h0000_0002);
      wr(4'h0, 32'h0000_0001);
      holdRead(4'h4);
      @(negedge PCLK);
      checkOutput("conv0_busy", PRDATA, 32'h0000_0001);
      @(negedge PCLK);
      checkOutput("conv0_done", PRDATA, 32'h0000_0002);
      @(posedge PCLK); #1;
      idleBus();
      rdCheck(4'h8, 32'h0000_0003, "conv0_result");

      $display("[TB] result wraps at 12 bits");
      wr(4'hC, 32'h0FFE_0001);
      wr(4'h4, 32'h0000_0002);
      wr(4'h0, 32'h0000_0001);
      waitDone(40, "wrap");
      rdCheck(4'h8, 32'h0000_0002, "wrap_result");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
